seq_alu: RTL and testbench

Registered, parametrised arithmetic/logic unit for the PucCPU datapath, replacing the purely combinational 8-bit ALU. It accepts one operation per `start` pulse, registers the result together with zero/carry/negative flags, and signals completion with a one-cycle `done`. Most operations complete in one cycle. MUL runs as a WIDTH-cycle shift-add sequence, with `busy` held high for the duration. The control unit sits upstream and drives `start`. The register file sits downstream and captures `aluResult` on `done`.

---
 rtl/puc_alu_pkg.sv | 24 ++
 rtl/shift_add_multiplier.sv | 61 ++++++
 rtl/seq_alu.sv | 159 +++++++++++++++
 tb/tb_seq_alu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/puc_alu_pkg.sv
// Shared opcode map and FSM state type for the PucCPU sequential ALU.
package puc_alu_pkg;

    localparam int unsigned OP_LOADSWITCH = 0;
    localparam int unsigned OP_LOAD       = 1;
    localparam int unsigned OP_ADD        = 2;
    localparam int unsigned OP_LSHIFT     = 3;
    localparam int unsigned OP_RSHIFT     = 4;
    localparam int unsigned OP_INC        = 5;
    localparam int unsigned OP_DEC        = 6;
    localparam int unsigned OP_AND        = 7;
    localparam int unsigned OP_OR         = 8;
    localparam int unsigned OP_XOR        = 9;
    localparam int unsigned OP_SUB        = 10;
    localparam int unsigned OP_MUL        = 11;
    localparam int unsigned OP_ILLEGAL_LO = 12;
    localparam int unsigned OP_ILLEGAL_HI = 15;

    typedef enum logic {
        IDLE     = 1'b0,
        MULTIPLY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Unsigned shift-add multiplier: one partial product per step, WIDTH steps per product.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);
    import puc_alu_pkg::*;

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // product is the accumulator value after the current step; the top captures it on last
    always_comb begin
        product = acc_q + (b_q[0] ? a_q : '0);
        last    = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            a_d   = {{WIDTH{1'b0}}, a_in};
            b_d   = b_in;
            acc_d = '0;
            cnt_d = '0;
        end else if (step) begin
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            acc_d = product;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops finish in one clock, MUL runs WIDTH shift-add steps.
module seq_alu #(
    parameter int WIDTH        = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] opCode,
    input  logic [WIDTH-1:0]        register1Value,
    input  logic [WIDTH-1:0]        register2Value,
    input  logic [WIDTH-1:0]        instructionValue,
    input  logic                    switch,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        aluResult,
    output logic [WIDTH-1:0]        aluResultHigh,
    output logic                    carry,
    output logic                    zero,
    output logic                    negative
);
    import puc_alu_pkg::*;

    // Returns {carry, result} for every opcode except MUL.
    function automatic logic [WIDTH:0] alu_single(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [WIDTH-1:0]        a,
        input logic [WIDTH-1:0]        b,
        input logic [WIDTH-1:0]        imm,
        input logic                    sw
    );
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OPCODE_WIDTH'(OP_LOADSWITCH): r = {1'b0, {(WIDTH-1){1'b0}}, sw};
            OPCODE_WIDTH'(OP_LOAD):       r = {1'b0, imm};
            OPCODE_WIDTH'(OP_ADD):        r = {1'b0, a} + {1'b0, b};
            OPCODE_WIDTH'(OP_LSHIFT):     r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
            OPCODE_WIDTH'(OP_RSHIFT):     r = {a[0], a[0], a[WIDTH-1:1]};
            OPCODE_WIDTH'(OP_INC):        r = {1'b0, a} + (WIDTH+1)'(1);
            OPCODE_WIDTH'(OP_DEC):        r = {1'b0, a} - (WIDTH+1)'(1);
            OPCODE_WIDTH'(OP_AND):        r = {1'b0, a & b};
            OPCODE_WIDTH'(OP_OR):         r = {1'b0, a | b};
            OPCODE_WIDTH'(OP_XOR):        r = {1'b0, a ^ b};
            OPCODE_WIDTH'(OP_SUB):        r = {1'b0, a} - {1'b0, b};
            default:                      r = '0;
        endcase
        return r;
    endfunction

    alu_state_e state_q, state_d;

    logic                 done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_high_q, result_high_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 negative_q, negative_d;

    logic                 is_mul;
    logic                 mul_load;
    logic                 mul_step;
    logic                 mul_last;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH:0]       single_res;

    always_comb begin
        is_mul     = (opCode == OPCODE_WIDTH'(OP_MUL));
        mul_load   = (state_q == IDLE) && start && is_mul;
        mul_step   = (state_q == MULTIPLY);
        single_res = alu_single(opCode, register1Value, register2Value,
                                instructionValue, switch);
    end

    shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .load    (mul_load),
        .step    (mul_step),
        .a_in    (register1Value),
        .b_in    (register2Value),
        .last    (mul_last),
        .product (mul_product)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start && is_mul) state_d = MULTIPLY;
            MULTIPLY: if (mul_last)        state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == MULTIPLY);
    end

    // Result registers only move on a completing cycle, so they hold between dones
    always_comb begin
        done_d        = 1'b0;
        result_d      = result_q;
        result_high_d = result_high_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        negative_d    = negative_q;
        if (state_q == IDLE && start && !is_mul) begin
            done_d        = 1'b1;
            result_d      = single_res[WIDTH-1:0];
            result_high_d = '0;
            carry_d       = single_res[WIDTH];
            zero_d        = (single_res[WIDTH-1:0] == '0);
            negative_d    = single_res[WIDTH-1];
        end else if (state_q == MULTIPLY && mul_last) begin
            done_d        = 1'b1;
            result_d      = mul_product[WIDTH-1:0];
            result_high_d = mul_product[2*WIDTH-1:WIDTH];
            carry_d       = (mul_product[2*WIDTH-1:WIDTH] != '0);
            zero_d        = (mul_product[WIDTH-1:0] == '0);
            negative_d    = mul_product[WIDTH-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q        <= 1'b0;
            result_q      <= '0;
            result_high_q <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            negative_q    <= 1'b0;
        end else begin
            done_q        <= done_d;
            result_q      <= result_d;
            result_high_q <= result_high_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
            negative_q    <= negative_d;
        end
    end

    assign done          = done_q;
    assign aluResult     = result_q;
    assign aluResultHigh = result_high_q;
    assign carry         = carry_q;
    assign zero          = zero_q;
    assign negative      = negative_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with a cycle-level arithmetic reference model.
module tb_seq_alu;
    localparam int    W  = 8;
    localparam int    OW = 4;
    localparam longint M = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [OW-1:0] op    = '0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic [W-1:0]  imm   = '0;
    logic          sw    = 1'b0;

    logic          busy, done, carry, zero, negative;
    logic [W-1:0]  res, hi;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clock = ~clock;

    seq_alu #(.WIDTH(W), .OPCODE_WIDTH(OW)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .opCode           (op),
        .register1Value   (a),
        .register2Value   (b),
        .instructionValue (imm),
        .switch           (sw),
        .busy             (busy),
        .done             (done),
        .aluResult        (res),
        .aluResultHigh    (hi),
        .carry            (carry),
        .zero             (zero),
        .negative         (negative)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference semantics in plain integer arithmetic; returns carry*M + result.
    function automatic longint ref_single(input logic [OW-1:0] opc, input logic [W-1:0] av_in,
                                          input logic [W-1:0] bv_in, input logic [W-1:0] iv_in,
                                          input logic swv);
        longint av, bv, r, c;
        av = longint'(av_in);
        bv = longint'(bv_in);
        r = 0;
        c = 0;
        case (int'(opc))
            0:  r = swv ? 1 : 0;
            1:  r = longint'(iv_in);
            2:  begin r = (av + bv) % M; c = (av + bv >= M) ? 1 : 0; end
            3:  begin r = (av * 2) % M + av / (M / 2); c = (av >= M / 2) ? 1 : 0; end
            4:  begin r = av / 2 + (av % 2) * (M / 2); c = av % 2; end
            5:  begin r = (av + 1) % M; c = (av + 1 >= M) ? 1 : 0; end
            6:  begin r = (av + M - 1) % M; c = (av == 0) ? 1 : 0; end
            7:  r = av & bv;
            8:  r = av | bv;
            9:  r = av ^ bv;
            10: begin r = (av + M - bv) % M; c = (av < bv) ? 1 : 0; end
            default: r = 0;
        endcase
        return c * M + r;
    endfunction

    longint mt, mp;
    always_comb begin
        mt = ref_single(op, a, b, imm, sw);
        mp = longint'(a) * longint'(b);
    end

    int           m_cnt;
    logic [W-1:0] m_res, m_hi, m_plo, m_phi;
    logic         m_c, m_z, m_n, m_done;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt <= 0; m_res <= '0; m_hi <= '0; m_plo <= '0; m_phi <= '0;
            m_c <= 1'b0; m_z <= 1'b0; m_n <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_res  <= m_plo;
                    m_hi   <= m_phi;
                    m_c    <= (m_phi != 0);
                    m_z    <= (m_plo == 0);
                    m_n    <= (longint'(m_plo) >= M / 2);
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (int'(op) == 11) begin
                    m_cnt <= W;
                    m_plo <= W'(mp % M);
                    m_phi <= W'(mp / M);
                end else begin
                    m_res  <= W'(mt % M);
                    m_hi   <= '0;
                    m_c    <= (mt >= M);
                    m_z    <= (mt % M == 0);
                    m_n    <= (mt % M >= M / 2);
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            cmp("model_busy",     32'(busy),     32'(m_cnt > 0));
            cmp("model_done",     32'(done),     32'(m_done));
            cmp("model_result",   32'(res),      32'(m_res));
            cmp("model_high",     32'(hi),       32'(m_hi));
            cmp("model_carry",    32'(carry),    32'(m_c));
            cmp("model_zero",     32'(zero),     32'(m_z));
            cmp("model_negative", 32'(negative), 32'(m_n));
        end
    end

    task automatic issue(input int opc, input int av, input int bv, input int iv, input bit swv);
        op    = OW'(opc);
        a     = W'(av);
        b     = W'(bv);
        imm   = W'(iv);
        sw    = swv;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic expect_flags(input string tag, input int r, input int h, input bit c,
                                input bit z, input bit n);
        cmp({tag, "_done"},   32'(done),     32'd1);
        cmp({tag, "_result"}, 32'(res),      32'(r));
        cmp({tag, "_high"},   32'(hi),       32'(h));
        cmp({tag, "_carry"},  32'(carry),    32'(c));
        cmp({tag, "_zero"},   32'(zero),     32'(z));
        cmp({tag, "_neg"},    32'(negative), 32'(n));
    endtask

    task automatic wait_mul(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clock);
        end
        cmp({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    int nd;

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        checking = 1'b1;
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_done", 32'(done), 32'd0);
        cmp("rst_result", 32'(res), 32'd0);
        cmp("rst_high", 32'(hi), 32'd0);
        cmp("rst_flags", 32'({carry, zero, negative}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        issue(2, 'hF0, 'h20, 0, 0);
        expect_flags("add", 'h10, 0, 1, 0, 0);

        issue(11, 'hFF, 'hFF, 0, 0);
        wait_mul("mul_ff", W);
        expect_flags("mul_ff", 'h01, 'hFE, 1, 0, 0);
        cmp("mul_ff_busy_at_done", 32'(busy), 32'd0);

        issue(2, 3, 4, 0, 0);
        expect_flags("add_after_mul", 'h07, 0, 0, 0, 0);

        issue(11, 'h0F, 'h11, 0, 0);
        wait_mul("mul_0f", W);
        expect_flags("mul_0f", 'hFF, 'h00, 0, 0, 1);

        issue(11, 'h12, 'h34, 0, 0);
        repeat (2) @(negedge clock);
        issue(2, 1, 1, 0, 0);
        a = 'h55;
        b = 'hAA;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) nd++;
            @(negedge clock);
        end
        cmp("ignored_start_dones", 32'(nd), 32'd1);
        cmp("ignored_start_result", 32'(res), 32'hA8);
        cmp("ignored_start_high", 32'(hi), 32'h03);

        issue(11, 'hFF, 'hFF, 0, 0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        cmp("abort_busy", 32'(busy), 32'd0);
        cmp("abort_result", 32'(res), 32'd0);
        cmp("abort_high", 32'(hi), 32'd0);
        cmp("abort_flags", 32'({carry, zero, negative}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) nd++;
        end
        cmp("abort_no_done", 32'(nd), 32'd0);

        issue(3, 'h81, 0, 0, 0);
        expect_flags("lshift", 'h03, 0, 1, 0, 0);
        issue(4, 'h01, 0, 0, 0);
        expect_flags("rshift", 'h80, 0, 1, 0, 1);
        issue(6, 'h00, 0, 0, 0);
        expect_flags("dec", 'hFF, 0, 1, 0, 1);
        issue(5, 'hFF, 0, 0, 0);
        expect_flags("inc", 'h00, 0, 1, 1, 0);
        issue(0, 0, 0, 0, 1);
        expect_flags("loadswitch", 'h01, 0, 0, 0, 0);
        issue(1, 0, 0, 'hA5, 0);
        expect_flags("load", 'hA5, 0, 0, 0, 1);
        issue(15, 'h33, 'h44, 'h55, 1);
        expect_flags("illegal", 'h00, 0, 0, 1, 0);
        issue(10, 'h10, 'h20, 0, 0);
        expect_flags("sub_borrow", 'hF0, 0, 1, 0, 1);

        issue(7, 'hCC, 'hAA, 0, 0);
        issue(8, 'hCC, 'hAA, 0, 0);
        issue(9, 'hCC, 'hCC, 0, 0);
        issue(10, 'h05, 'h05, 0, 0);
        issue(2, 'h7F, 'h01, 0, 0);
        expect_flags("b2b_add", 'h80, 0, 0, 0, 1);
        @(negedge clock);
        cmp("done_drops", 32'(done), 32'd0);
        @(negedge clock);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule
